pipe_skid_reg: RTL

PIPE_SKID_REG -- requirements
Module: pipe_skid_reg

---
 rtl/pipe_skid_reg.sv | 120 ++++++++++++
 1 files changed

// File: rtl/pipe_skid_reg.sv
// pipe_skid_reg: two-entry skid buffer between two pipeline stages.
//
// The buffer has a main register that drives the output and one skid register
// that holds an item when the downstream stage stalls. in_ready comes straight
// from a flop (~skid_v), so there is no combinational path from out_ready to
// in_ready.
//
// Parameters
//   DATA_W         payload width in bits
//   CLEAR_ON_FLUSH 1: a flush also zeroes the payload registers
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   upstream payload valid
//   in_data    upstream payload
//   in_ready   the buffer takes in_data this cycle
//   out_valid  out_data holds a valid payload
//   out_data   downstream payload, taken from the main register
//   out_ready  downstream consumes out_data this cycle
//   flush      drop every held entry; this has priority over accept and pop
//   occupancy  number of valid entries held (0..2)
//   stall_cnt  (only with PIPE_SKID_REG_PERF_EN) number of cycles with
//              main_v & ~out_ready; saturates and is cleared by flush
//
// Build option: define PIPE_SKID_REG_PERF_EN to add the stall_cnt output.
module pipe_skid_reg #(
    parameter int DATA_W         = 70,
    parameter bit CLEAR_ON_FLUSH = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ready,
    input  logic              flush,
`ifdef PIPE_SKID_REG_PERF_EN
    output logic [15:0]       stall_cnt,
`endif
    output logic [1:0]        occupancy
);

    logic              main_v;
    logic              skid_v;
    logic [DATA_W-1:0] main_d;
    logic [DATA_W-1:0] skid_d;
    logic              accept;
    logic              pop;

    assign accept = in_valid & ~skid_v;
    assign pop    = main_v & out_ready;

    // Valid bits. The pair (main_v, skid_v) only takes the values (0,0),
    // (1,0) and (1,1). The skid register fills only while main is held, and
    // it drains into main before main can empty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_v <= 1'b0;
            skid_v <= 1'b0;
        end else if (flush) begin
            main_v <= 1'b0;
            skid_v <= 1'b0;
        end else if (pop && skid_v) begin
            // The skid entry moves into main, so main stays valid.
            // No accept can happen here because in_ready is 0.
            skid_v <= 1'b0;
        end else if (accept) begin
            if (!main_v || pop) begin
                main_v <= 1'b1;
            end else begin
                skid_v <= 1'b1;
            end
        end else if (pop) begin
            main_v <= 1'b0;
        end
    end

    // Payload registers. When main empties, main_d keeps its last value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_d <= '0;
            skid_d <= '0;
        end else if (flush) begin
            if (CLEAR_ON_FLUSH) begin
                main_d <= '0;
                skid_d <= '0;
            end
        end else if (pop && skid_v) begin
            main_d <= skid_d;
        end else if (accept) begin
            if (!main_v || pop) begin
                main_d <= in_data;
            end else begin
                skid_d <= in_data;
            end
        end
    end

    assign in_ready  = ~skid_v;
    assign out_valid = main_v;
    assign out_data  = main_d;
    assign occupancy = {1'b0, main_v} + {1'b0, skid_v};

`ifdef PIPE_SKID_REG_PERF_EN
    // Stall counter: counts cycles where a valid output is held back.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
        end else if (flush) begin
            stall_cnt <= '0;
        end else if (main_v && !out_ready && (stall_cnt != 16'hFFFF)) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end
`endif

endmodule
